// File: rtl/apb_fsm_controller_if.sv
// AHB-side / APB-side signal bundle for the AHB-to-APB bridge sequencer.
// slave  : view of the sequencer (apb_fsm_controller)
// master : view of the surrounding bridge logic (AHB slave stage + APB peripherals)
// Optional macro APB_PREADY_EN adds the pready signal.
interface apb_fsm_controller_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSEL   = 3
) ();
  logic              valid;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic              hwrite;
  logic [NSEL-1:0]   tempselx;
  logic [DATA_W-1:0] prdata_in;
`ifdef APB_PREADY_EN
  logic              pready;
`endif
  logic              hreadyout;
  logic [DATA_W-1:0] hrdata;
  logic              pwrite;
  logic              penable;
  logic [NSEL-1:0]   pselx;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;

  modport slave (
    input  valid, haddr, hwdata, hwrite, tempselx, prdata_in,
`ifdef APB_PREADY_EN
    input  pready,
`endif
    output hreadyout, hrdata, pwrite, penable, pselx, paddr, pwdata
  );

  modport master (
    output valid, haddr, hwdata, hwrite, tempselx, prdata_in,
`ifdef APB_PREADY_EN
    output pready,
`endif
    input  hreadyout, hrdata, pwrite, penable, pselx, paddr, pwdata
  );
endinterface

// File: rtl/apb_fsm_controller.sv
// APB master sequencer of the AHB-to-APB bridge. Turns each accepted AHB
// transfer into an APB SETUP->ACCESS pair and stalls AHB through hreadyout.
// Optional macro APB_PREADY_EN: ACCESS is extended while pready is low.
//
// state  | meaning
// IDLE   | no transfer; hreadyout=1, pselx=0
// WWAIT  | write accepted, waiting one cycle for hwdata (data phase)
// SETUP  | APB setup phase: pselx/paddr valid, penable=0
// ACCESS | APB access phase: penable=1; last cycle has hreadyout=1
module apb_fsm_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSEL   = 3
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  apb_fsm_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WWAIT, SETUP, ACCESS} state_t;

  state_t            state_q, state_d;
  logic              pwrite_q, pwrite_d;
  logic              penable_q, penable_d;
  logic [NSEL-1:0]   pselx_q, pselx_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;

  logic access_done;
  logic hready;
  logic accept;

`ifdef APB_PREADY_EN
  assign access_done = (state_q == ACCESS) && bus.pready;
`else
  assign access_done = (state_q == ACCESS);
`endif

  // AHB may only present a new transfer when we are idle or finishing ACCESS;
  // an all-zero select means the address decoded to no peripheral.
  assign hready = (state_q == IDLE) || access_done;
  assign accept = hready && bus.valid && (|bus.tempselx);

  // State and APB output registers
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= IDLE;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      pselx_q   <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      pselx_q   <= pselx_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  // Next-state and next APB output values; everything holds unless changed.
  // Select is driven from the accept edge so a back-to-back write never
  // drops pselx during its WWAIT cycle.
  always_comb begin
    state_d   = state_q;
    pwrite_d  = pwrite_q;
    penable_d = penable_q;
    pselx_d   = pselx_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = bus.hwrite ? WWAIT : SETUP;
          pwrite_d  = bus.hwrite;
          pselx_d   = bus.tempselx;
          paddr_d   = bus.haddr;
          penable_d = 1'b0;
        end
      end
      WWAIT: begin
        pwdata_d = bus.hwdata;
        state_d  = SETUP;
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (access_done) begin
          penable_d = 1'b0;
          if (accept) begin
            state_d  = bus.hwrite ? WWAIT : SETUP;
            pwrite_d = bus.hwrite;
            pselx_d  = bus.tempselx;
            paddr_d  = bus.haddr;
          end else begin
            state_d = IDLE;
            pselx_d = '0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        penable_d = 1'b0;
        pselx_d   = '0;
      end
    endcase
  end

  // Output drive; read data passes straight through during a read ACCESS
  always_comb begin
    bus.hreadyout = hready;
    bus.hrdata    = ((state_q == ACCESS) && !pwrite_q) ? bus.prdata_in : '0;
    bus.pwrite    = pwrite_q;
    bus.penable   = penable_q;
    bus.pselx     = pselx_q;
    bus.paddr     = paddr_q;
    bus.pwdata    = pwdata_q;
  end

endmodule

// File: tb/tb_apb_fsm_controller.sv
module tb_apb_fsm_controller;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NSEL   = 3;

  logic Hclk = 1'b0;
  logic Hresetn;
  always #5 Hclk = ~Hclk;

  apb_fsm_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSEL(NSEL)) bus ();

  apb_fsm_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSEL(NSEL)) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus)
  );

  typedef struct {
    logic              wr;
    logic [NSEL-1:0]   sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  txn_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic drive_req(input logic wr, input logic [NSEL-1:0] sel,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] rdata);
    bus.valid     = 1'b1;
    bus.hwrite    = wr;
    bus.tempselx  = sel;
    bus.haddr     = addr;
    bus.prdata_in = rdata;
  endtask

  task automatic push(input logic wr, input logic [NSEL-1:0] sel,
                      input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    txn_t t;
    t.wr = wr; t.sel = sel; t.addr = addr; t.data = data;
    sb.push_back(t);
  endtask

  task automatic idle_bus();
    bus.valid    = 1'b0;
    bus.tempselx = '0;
  endtask

  // Monitor: every completed APB transfer is popped from the scoreboard
  always @(negedge Hclk) begin : monitor
    txn_t e;
    if (Hresetn === 1'b1 && bus.penable === 1'b1 && bus.hreadyout === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("sb_pwrite", bus.pwrite, e.wr);
        chk("sb_pselx", bus.pselx, e.sel);
        chk("sb_paddr", bus.paddr, e.addr);
        if (e.wr) chk("sb_pwdata", bus.pwdata, e.data);
        else      chk("sb_hrdata", bus.hrdata, e.data);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    Hresetn       = 1'b0;
    bus.valid     = 1'b0;
    bus.haddr     = '0;
    bus.hwdata    = '0;
    bus.hwrite    = 1'b0;
    bus.tempselx  = '0;
    bus.prdata_in = '0;
`ifdef APB_PREADY_EN
    bus.pready    = 1'b1;
`endif
    repeat (2) step();
    @(negedge Hclk);
    chk("rst_hready", bus.hreadyout, 1);
    chk("rst_pselx", bus.pselx, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_paddr", bus.paddr, 0);
    step();
    Hresetn = 1'b1;
    @(negedge Hclk);
    chk("idle_hready", bus.hreadyout, 1);

    // Single read
    step();
    drive_req(1'b0, 3'b001, 32'h8000_0010, 32'h19);
    push(1'b0, 3'b001, 32'h8000_0010, 32'h19);
    @(negedge Hclk);
    step();
    idle_bus();
    @(negedge Hclk);
    chk("rd_setup_pselx", bus.pselx, 3'b001);
    chk("rd_setup_penable", bus.penable, 0);
    chk("rd_setup_paddr", bus.paddr, 32'h8000_0010);
    chk("rd_setup_hready", bus.hreadyout, 0);
    chk("rd_setup_pwrite", bus.pwrite, 0);
    step();
    @(negedge Hclk);
    chk("rd_access_penable", bus.penable, 1);
    chk("rd_access_hrdata", bus.hrdata, 32'h19);
    chk("rd_access_hready", bus.hreadyout, 1);
    step();
    @(negedge Hclk);
    chk("rd_after_pselx", bus.pselx, 0);
    chk("rd_after_penable", bus.penable, 0);
    chk("rd_after_hrdata", bus.hrdata, 0);

    // Single write
    step();
    drive_req(1'b1, 3'b010, 32'h8400_0020, 32'h0);
    push(1'b1, 3'b010, 32'h8400_0020, 32'hDEAD_BEEF);
    @(negedge Hclk);
    step();
    idle_bus();
    bus.hwdata = 32'hDEAD_BEEF;
    @(negedge Hclk);
    chk("wr_wwait_hready", bus.hreadyout, 0);
    chk("wr_wwait_penable", bus.penable, 0);
    step();
    bus.hwdata = '0;
    @(negedge Hclk);
    chk("wr_setup_pwdata", bus.pwdata, 32'hDEAD_BEEF);
    chk("wr_setup_pwrite", bus.pwrite, 1);
    chk("wr_setup_penable", bus.penable, 0);
    chk("wr_setup_pselx", bus.pselx, 3'b010);
    chk("wr_setup_hready", bus.hreadyout, 0);
    step();
    @(negedge Hclk);
    chk("wr_access_penable", bus.penable, 1);
    chk("wr_access_hready", bus.hreadyout, 1);
    chk("wr_access_hrdata", bus.hrdata, 0);
    step();
    @(negedge Hclk);
    chk("wr_after_pselx", bus.pselx, 0);

    // Back-to-back: read A then write B held valid
    step();
    drive_req(1'b0, 3'b100, 32'h8000_0100, 32'h1234);
    push(1'b0, 3'b100, 32'h8000_0100, 32'h1234);
    @(negedge Hclk);
    step();
    drive_req(1'b1, 3'b001, 32'h8800_0040, 32'h1234);
    push(1'b1, 3'b001, 32'h8800_0040, 32'hCAFE_F00D);
    @(negedge Hclk);
    chk("b2b_setup_pselx", bus.pselx, 3'b100);
    chk("b2b_setup_hready", bus.hreadyout, 0);
    step();
    @(negedge Hclk);
    chk("b2b_access_penable", bus.penable, 1);
    chk("b2b_access_hrdata", bus.hrdata, 32'h1234);
    step();
    idle_bus();
    bus.hwdata = 32'hCAFE_F00D;
    @(negedge Hclk);
    chk("b2b_wwait_pselx", bus.pselx, 3'b001);
    chk("b2b_wwait_paddr", bus.paddr, 32'h8800_0040);
    chk("b2b_wwait_penable", bus.penable, 0);
    chk("b2b_wwait_hready", bus.hreadyout, 0);
    step();
    bus.hwdata = '0;
    @(negedge Hclk);
    chk("b2b_setup2_pselx", bus.pselx, 3'b001);
    chk("b2b_setup2_pwdata", bus.pwdata, 32'hCAFE_F00D);
    step();
    @(negedge Hclk);
    chk("b2b_access2_penable", bus.penable, 1);
    step();
    @(negedge Hclk);
    chk("b2b_after_pselx", bus.pselx, 0);

    // Invalid select is ignored
    step();
    drive_req(1'b0, 3'b000, 32'h8000_0300, 32'h55);
    for (int i = 0; i < 3; i++) begin
      @(negedge Hclk);
      chk("nosel_pselx", bus.pselx, 0);
      chk("nosel_hready", bus.hreadyout, 1);
      chk("nosel_penable", bus.penable, 0);
      step();
    end
    idle_bus();

`ifdef APB_PREADY_EN
    // ACCESS stretched by pready=0 for three cycles
    drive_req(1'b0, 3'b001, 32'h8000_0500, 32'h77);
    push(1'b0, 3'b001, 32'h8000_0500, 32'h77);
    @(negedge Hclk);
    step();
    idle_bus();
    bus.pready = 1'b0;
    @(negedge Hclk);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge Hclk);
      chk("wait_penable", bus.penable, 1);
      chk("wait_hready", bus.hreadyout, 0);
      chk("wait_pselx", bus.pselx, 3'b001);
    end
    step();
    bus.pready = 1'b1;
    @(negedge Hclk);
    chk("wait_done_hready", bus.hreadyout, 1);
    step();
    @(negedge Hclk);
    chk("wait_after_pselx", bus.pselx, 0);
    step();
`endif

    // Reset asserted in the middle of ACCESS; transfer is not replayed
    drive_req(1'b0, 3'b010, 32'h8000_0200, 32'h66);
    @(negedge Hclk);
    step();
    idle_bus();
    @(negedge Hclk);
    chk("rstmid_setup_pselx", bus.pselx, 3'b010);
    step();
    chk("rstmid_access_penable", bus.penable, 1);
    #1;
    Hresetn = 1'b0;
    @(negedge Hclk);
    chk("rstmid_pselx", bus.pselx, 0);
    chk("rstmid_penable", bus.penable, 0);
    chk("rstmid_pwrite", bus.pwrite, 0);
    chk("rstmid_paddr", bus.paddr, 0);
    chk("rstmid_pwdata", bus.pwdata, 0);
    chk("rstmid_hrdata", bus.hrdata, 0);
    chk("rstmid_hready", bus.hreadyout, 1);
    step();
    Hresetn = 1'b1;
    @(negedge Hclk);
    chk("rstmid_idle_pselx", bus.pselx, 0);
    chk("rstmid_idle_hready", bus.hreadyout, 1);

    // Recovery read after reset
    step();
    drive_req(1'b0, 3'b100, 32'h8000_0400, 32'hA5);
    push(1'b0, 3'b100, 32'h8000_0400, 32'hA5);
    @(negedge Hclk);
    step();
    idle_bus();
    @(negedge Hclk);
    chk("rec_setup_paddr", bus.paddr, 32'h8000_0400);
    step();
    @(negedge Hclk);
    chk("rec_access_hrdata", bus.hrdata, 32'hA5);
    step();
    @(negedge Hclk);
    chk("rec_after_penable", bus.penable, 0);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
